ysyx_23060203_lsu: RTL
======================

Name: ysyx_23060203_lsu

Overview:
- Load/store stage between EXU and WBU.
- Takes one instruction at a time from EXU over a valid/ready handshake.
- For loads and stores, runs one AXI4-Lite style transaction on the data bus. Loads are aligned and sign/zero-extended.
- Presents the completed instruction to WBU: GPR write, CSR write, exc/ret/fencei pass-through.

Parameters:
- none (XLEN fixed at 32).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_ready  out  1  EXU handshake
- in_valid  in  1  EXU handshake
- in_pc  in  32  instruction PC
- in_gpr_waddr  in  5  destination register (0 = no write)
- in_gpr_wdata  in  32  ALU/CSR result for non-load instructions
- in_mem_ren  in  1  instruction is a load
- in_mem_wen  in  1  instruction is a store
- in_mem_funct3  in  3  access type
- in_mem_addr  in  32  effective address
- in_mem_wdata  in  32  store data (rs2)
- in_csr_wen, in_csr_waddr[12], in_csr_wdata[32], in_exc, in_ret, in_fencei  in  passed through to WBU
- out_valid  out  1  WBU handshake
- out_ready  in  1  WBU handshake
- out_pc, out_gpr_waddr, out_gpr_wdata, out_csr_wen, out_csr_waddr, out_csr_wdata, out_exc, out_ret, out_fencei  out  WBU payload, same widths as inputs
- araddr[32], arvalid out; arready in  read address channel
- rdata[32], rresp[2], rvalid in; rready out  read data channel
- awaddr[32], awvalid out; awready in  write address channel
- wdata[32], wstrb[4], wvalid out; wready in  write data channel
- bresp[2], bvalid in; bready out  write response channel

Behaviour:
- Reset: state IDLE; out_valid, arvalid, rready, awvalid, wvalid, bready all 0.
- Reset mid-transaction abandons it immediately. No waiting for the bus; the pending response is dropped.
- in_ready = (state==IDLE) & (~out_valid | out_ready). Payload is latched on in_valid & in_ready.
- FSM states: IDLE, RADDR, RDATA, WREQ, WRESP.
- Non-memory instruction: stays IDLE. out_valid=1 the next cycle with out_gpr_wdata=in_gpr_wdata (1-cycle latency).
- Load: IDLE→RADDR, arvalid=1, araddr=in_mem_addr.
  - On arready: →RDATA, rready=1.
  - On rvalid: result formed, out_valid=1 that same edge, →IDLE.
- Store: IDLE→WREQ with awvalid=wvalid=1, awaddr=in_mem_addr.
  - Each valid drops independently on its own handshake; AW and W may complete in either order or together.
  - When both are done: →WRESP, bready=1.
  - On bvalid: out_valid=1, →IDLE. out_gpr_wdata for a store is don't-care.
- in_mem_ren & in_mem_wen together is illegal; load takes priority.
- Load extraction: shifted = rdata >> (addr[1:0]*8).
  - funct3 000 LB: sign-extend [7:0]
  - 001 LH: sign-extend [15:0]
  - 010 LW: full word
  - 100 LBU: zero-extend [7:0]
  - 101 LHU: zero-extend [15:0]
  - Others: full word.
- Store encoding:
  - wdata = in_mem_wdata << (addr[1:0]*8), truncated to 32 bits.
  - wstrb: SB = 4'b0001<<addr[1:0]; SH = 4'b0011<<addr[1:0] (truncated to 4 bits); SW = 4'b1111.
- Misaligned accesses: no trap. Truncation above is the defined result.
- Output register: holds its value while out_valid & ~out_ready.
  - out_valid & out_ready with new in_valid in the same cycle: new payload loads and out_valid stays 1 (back-to-back, non-memory).
  - For a memory op, out_valid drops after the handshake until the bus completes.
- Bus valids and addresses stay stable until their handshake.

Optional Feature:
- Macro: LSU_BUS_ERR_EN.
- Defined: rresp!=0 or bresp!=0 forces out_exc=1 and out_gpr_waddr=0 for that instruction. WBU then redirects to mtvec and records mepc. Pass-through fields are otherwise unchanged.
- Undefined: rresp/bresp are ignored; loads always write rdata-derived data.

Test Plan:
- ADDI-type input (ren=wen=0, waddr=5, wdata=0x1234), out_ready=1 → out_valid next cycle with waddr=5, wdata=0x1234; in_ready stays 1 for back-to-back issue.
- LB addr=0x80000003, rdata=0x80FF_0000, arready/rvalid delayed 2 cycles each → out_gpr_wdata=0xFFFFFF80; LBU same → 0x00000080.
- SH addr=0x80000002, wdata=0x0000ABCD, awready one cycle before wready → wstrb=4'b1100, wdata=0xABCD0000; out_valid only after bvalid.
- out_ready held 0 for 3 cycles after a load completes → out payload stable, in_ready=0, no new arvalid.
- reset asserted while in RDATA → next cycle all valids 0, state IDLE; a late rvalid is ignored; next load completes normally.
- LSU_BUS_ERR_EN defined, LW with rresp=2'b10 → out_exc=1, out_gpr_waddr=0; undefined → out_exc=in_exc, data written.

Source files
------------

// File: rtl/ysyx_23060203_lsu.sv
// rtl/ysyx_23060203_lsu.sv - load/store stage with AXI4-Lite style data bus
// Optional LSU_BUS_ERR_EN: nonzero rresp/bresp raises out_exc and suppresses the GPR write.
module ysyx_23060203_lsu (
   input  logic        clock,
   input  logic        reset,
   output logic        in_ready,
   input  logic        in_valid,
   input  logic [31:0] in_pc,
   input  logic [4:0]  in_gpr_waddr,
   input  logic [31:0] in_gpr_wdata,
   input  logic        in_mem_ren,
   input  logic        in_mem_wen,
   input  logic [2:0]  in_mem_funct3,
   input  logic [31:0] in_mem_addr,
   input  logic [31:0] in_mem_wdata,
   input  logic        in_csr_wen,
   input  logic [11:0] in_csr_waddr,
   input  logic [31:0] in_csr_wdata,
   input  logic        in_exc,
   input  logic        in_ret,
   input  logic        in_fencei,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [4:0]  out_gpr_waddr,
   output logic [31:0] out_gpr_wdata,
   output logic        out_csr_wen,
   output logic [11:0] out_csr_waddr,
   output logic [31:0] out_csr_wdata,
   output logic        out_exc,
   output logic        out_ret,
   output logic        out_fencei,
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rvalid,
   output logic        rready,
   output logic [31:0] awaddr,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wvalid,
   input  logic        wready,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready
);

   typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP} state_t;

   state_t      state, state_next;
   logic        fire, mem_done, bus_err;
   logic        aw_pend, w_pend, aw_ok, w_ok;
   logic [31:0] mem_addr, mem_wdata, shifted, load_data;
   logic [2:0]  mem_funct3;
   logic [1:0]  off;

   assign in_ready = (state == IDLE) & (~out_valid | out_ready);
   assign fire     = in_valid & in_ready;
   assign off      = mem_addr[1:0];

   assign araddr  = mem_addr;
   assign awaddr  = mem_addr;
   assign arvalid = (state == RADDR);
   assign rready  = (state == RDATA);
   assign awvalid = (state == WREQ) & aw_pend;
   assign wvalid  = (state == WREQ) & w_pend;
   assign bready  = (state == WRESP);

   // Each write channel is "ok" once its handshake has happened or happens now.
   assign aw_ok    = ~aw_pend | awready;
   assign w_ok     = ~w_pend | wready;
   assign mem_done = ((state == RDATA) & rvalid) | ((state == WRESP) & bvalid);

`ifdef LSU_BUS_ERR_EN
   assign bus_err = (state == RDATA) ? (rresp != 2'b00) : (bresp != 2'b00);
`else
   logic unused_resp;
   assign unused_resp = ^{rresp, bresp};
   assign bus_err     = 1'b0;
`endif

   assign shifted = rdata >> {off, 3'b000};
   assign wdata   = mem_wdata << {off, 3'b000};

   always_comb begin
      load_data = shifted;
      case (mem_funct3)
         3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  load_data = {24'd0, shifted[7:0]};
         3'b101:  load_data = {16'd0, shifted[15:0]};
         default: load_data = shifted;
      endcase
   end

   always_comb begin
      wstrb = 4'b1111;
      case (mem_funct3[1:0])
         2'b00:   wstrb = 4'b0001 << off;
         2'b01:   wstrb = 4'b0011 << off;
         default: wstrb = 4'b1111;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (fire & in_mem_ren)      state_next = RADDR;
            else if (fire & in_mem_wen) state_next = WREQ;
         end
         RADDR:   if (arready) state_next = RDATA;
         RDATA:   if (rvalid) state_next = IDLE;
         WREQ:    if (aw_ok & w_ok) state_next = WRESP;
         WRESP:   if (bvalid) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The output register doubles as the in-flight instruction buffer.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid     <= 1'b0;
         aw_pend       <= 1'b0;
         w_pend        <= 1'b0;
         out_pc        <= 32'd0;
         out_gpr_waddr <= 5'd0;
         out_gpr_wdata <= 32'd0;
         out_csr_wen   <= 1'b0;
         out_csr_waddr <= 12'd0;
         out_csr_wdata <= 32'd0;
         out_exc       <= 1'b0;
         out_ret       <= 1'b0;
         out_fencei    <= 1'b0;
         mem_addr      <= 32'd0;
         mem_wdata     <= 32'd0;
         mem_funct3    <= 3'd0;
      end else begin
         if (fire) begin
            out_valid     <= ~(in_mem_ren | in_mem_wen);
            aw_pend       <= in_mem_wen & ~in_mem_ren;
            w_pend        <= in_mem_wen & ~in_mem_ren;
            out_pc        <= in_pc;
            out_gpr_waddr <= in_gpr_waddr;
            out_gpr_wdata <= in_gpr_wdata;
            out_csr_wen   <= in_csr_wen;
            out_csr_waddr <= in_csr_waddr;
            out_csr_wdata <= in_csr_wdata;
            out_exc       <= in_exc;
            out_ret       <= in_ret;
            out_fencei    <= in_fencei;
            mem_addr      <= in_mem_addr;
            mem_wdata     <= in_mem_wdata;
            mem_funct3    <= in_mem_funct3;
         end else if (mem_done) begin
            out_valid <= 1'b1;
            if (state == RDATA) out_gpr_wdata <= load_data;
            if (bus_err) begin
               out_exc       <= 1'b1;
               out_gpr_waddr <= 5'd0;
            end
         end else if (out_valid & out_ready) begin
            out_valid <= 1'b0;
         end
         if (state == WREQ) begin
            if (awready) aw_pend <= 1'b0;
            if (wready)  w_pend  <= 1'b0;
         end
      end
   end

endmodule
